// File: rtl/activation_scheduler.sv
// activation_scheduler
// Shares one activation lane across NUM_INPUTS channels. An accepted vector is
// processed one valid lane per cycle, lowest index first. Invalid lanes are
// skipped without costing a cycle. The finished vector is then held on the
// output until the downstream stage accepts it.
module activation_scheduler #(
    parameter string ACTIVATION_FUNCTION = "ReLU",
    parameter int    DATA_WIDTH          = 12,
    parameter int    NUM_INPUTS          = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  activation_scheduler_ready_in,
    input  logic [NUM_INPUTS-1:0] activation_scheduler_valid_in,
    input  logic [DATA_WIDTH-1:0] activation_scheduler_data_in [0:NUM_INPUTS-1],
    input  logic                  activation_scheduler_ready_out,
    output logic [NUM_INPUTS-1:0] activation_scheduler_valid_out,
    output logic [DATA_WIDTH-1:0] activation_scheduler_data_out [0:NUM_INPUTS-1],
    output logic                  activation_scheduler_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] data_reg     [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0] result_reg   [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0] data_out_reg [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0] result_next  [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0] act_val      [0:NUM_INPUTS-1];
    logic [NUM_INPUTS-1:0] pending_reg;
    logic [NUM_INPUTS-1:0] out_mask_reg;
    logic [NUM_INPUTS-1:0] valid_out_reg;
    logic [NUM_INPUTS-1:0] lane_onehot;
    logic [NUM_INPUTS-1:0] pending_next;

    // The lowest set pending bit is isolated with x & -x. This picks the next
    // valid lane in one step, so invalid lanes cost no cycles.
    assign lane_onehot  = pending_reg & (~pending_reg + NUM_INPUTS'(1));
    assign pending_next = pending_reg & ~lane_onehot;

    // Each lane has a fixed activation tap. Only the selected lane's result is
    // written back.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
            if (ACTIVATION_FUNCTION == "ReLU") begin : g_relu
                assign act_val[gi] = data_reg[gi][DATA_WIDTH-1] ? '0 : data_reg[gi];
            end else begin : g_pass
                assign act_val[gi] = data_reg[gi];
            end
            assign result_next[gi] = lane_onehot[gi] ? act_val[gi] : result_reg[gi];
            assign activation_scheduler_data_out[gi] = data_out_reg[gi];
        end
    endgenerate

    assign activation_scheduler_ready_in  = (state_reg == IDLE);
    assign activation_scheduler_busy      = (state_reg != IDLE);
    assign activation_scheduler_valid_out = valid_out_reg;

    // This is the control FSM. The output vector is registered only on entry
    // to DONE, so data_out is stable throughout RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            out_mask_reg  <= '0;
            valid_out_reg <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                data_reg[i]     <= '0;
                result_reg[i]   <= '0;
                data_out_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (activation_scheduler_valid_in != '0) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            data_reg[i]   <= activation_scheduler_data_in[i];
                            result_reg[i] <= '0;
                        end
                        pending_reg  <= activation_scheduler_valid_in;
                        out_mask_reg <= activation_scheduler_valid_in;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        result_reg[i] <= result_next[i];
                    end
                    pending_reg <= pending_next;
                    if (pending_next == '0) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            data_out_reg[i] <= result_next[i];
                        end
                        valid_out_reg <= out_mask_reg;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (activation_scheduler_ready_out) begin
                        valid_out_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_scheduler.sv
// Bench for activation_scheduler. It uses a ReLU instance and a passthrough
// instance. Expected vectors are queued when stimulus is issued, and monitors
// compare them on each output handshake.
module tb_activation_scheduler;

    localparam int W = 12;
    localparam int N = 5;

    typedef struct packed {
        logic [N-1:0]   mask;
        logic [N*W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         rdy_a, ro_a, busy_a, rdy_b, ro_b, busy_b;
    logic [N-1:0] vi_a, vo_a, vi_b, vo_b;
    logic [W-1:0] di_a [0:N-1];
    logic [W-1:0] do_a [0:N-1];
    logic [W-1:0] di_b [0:N-1];
    logic [W-1:0] do_b [0:N-1];
    logic [N*W-1:0] do_a_flat, do_b_flat;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t qa[$];
    exp_t qb[$];

    activation_scheduler #(.ACTIVATION_FUNCTION("ReLU"), .DATA_WIDTH(W), .NUM_INPUTS(N)) dut_a (
        .clk(clk), .rst(rst),
        .activation_scheduler_ready_in(rdy_a),
        .activation_scheduler_valid_in(vi_a),
        .activation_scheduler_data_in(di_a),
        .activation_scheduler_ready_out(ro_a),
        .activation_scheduler_valid_out(vo_a),
        .activation_scheduler_data_out(do_a),
        .activation_scheduler_busy(busy_a)
    );

    activation_scheduler #(.ACTIVATION_FUNCTION("none"), .DATA_WIDTH(W), .NUM_INPUTS(N)) dut_b (
        .clk(clk), .rst(rst),
        .activation_scheduler_ready_in(rdy_b),
        .activation_scheduler_valid_in(vi_b),
        .activation_scheduler_data_in(di_b),
        .activation_scheduler_ready_out(ro_b),
        .activation_scheduler_valid_out(vo_b),
        .activation_scheduler_data_out(do_b),
        .activation_scheduler_busy(busy_b)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_flat
            assign do_a_flat[gi*W +: W] = do_a[gi];
            assign do_b_flat[gi*W +: W] = do_b[gi];
        end
    endgenerate

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N*W-1:0] pack5(int a0, int a1, int a2, int a3, int a4);
        logic [N*W-1:0] r;
        r[0*W +: W] = 12'(a0);
        r[1*W +: W] = 12'(a1);
        r[2*W +: W] = 12'(a2);
        r[3*W +: W] = 12'(a3);
        r[4*W +: W] = 12'(a4);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Monitor A pops and compares one expected vector per output handshake.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst && ro_a && vo_a != '0) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_a: unexpected output mask=%b, none expected", vo_a);
            end else begin
                e = qa.pop_front();
                chk("mon_a_mask", 64'(vo_a), 64'(e.mask));
                chk("mon_a_data", 64'(do_a_flat), 64'(e.data));
            end
        end
    end

    // Monitor B pops and compares one expected vector per output handshake.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst && ro_b && vo_b != '0) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_b: unexpected output mask=%b, none expected", vo_b);
            end else begin
                e = qb.pop_front();
                chk("mon_b_mask", 64'(vo_b), 64'(e.mask));
                chk("mon_b_data", 64'(do_b_flat), 64'(e.data));
            end
        end
    end

    task automatic set_a(input logic [N*W-1:0] d);
        for (int i = 0; i < N; i++) di_a[i] = d[i*W +: W];
    endtask

    task automatic set_b(input logic [N*W-1:0] d);
        for (int i = 0; i < N; i++) di_b[i] = d[i*W +: W];
    endtask

    // Wait for ready_in, present the vector for one edge, then drop valid.
    task automatic send_a(input logic [N-1:0] m, input logic [N*W-1:0] din,
                          input logic [N*W-1:0] dexp);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!rdy_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_a) begin
            total++; bad++;
            $display("FAIL send_a_timeout: ready_in=%b after %0d cycles, required 1", rdy_a, t);
        end
        vi_a = m;
        set_a(din);
        e.mask = m;
        e.data = dexp;
        qa.push_back(e);
        @(posedge clk); #1;
        vi_a = '0;
        chk("accept_busy_a", 64'(busy_a), 64'd1);
    endtask

    // valid_out must be low for k-1 edges and equal to the mask on edge k.
    task automatic lat_a(input int k, input logic [N-1:0] m, input string nm);
        for (int i = 1; i <= k; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_vo_edge%0d", nm, i), 64'(vo_a), (i < k) ? 64'd0 : 64'(m));
        end
    endtask

    // Valid is left asserted so that back-to-back accepts happen.
    task automatic send_b(input logic [N*W-1:0] din, output int acc_cyc);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!rdy_b && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_b) begin
            total++; bad++;
            $display("FAIL send_b_timeout: ready_in=%b after %0d cycles, required 1", rdy_b, t);
        end
        vi_b = '1;
        set_b(din);
        e.mask = '1;
        e.data = din;
        qb.push_back(e);
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    initial begin
        int a1, a2, t;
        vi_a = '0; vi_b = '0; ro_a = 1'b1; ro_b = 1'b1;
        set_a('0); set_b('0);

        // Check the reset state.
        #12;
        chk("rst_ready_in", 64'(rdy_a), 64'd1);
        chk("rst_valid_out", 64'(vo_a), 64'd0);
        chk("rst_data_out", 64'(do_a_flat), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Send a full ReLU vector.
        send_a(5'b11111, pack5(-3, 7, 0, -2048, 2047), pack5(0, 7, 0, 0, 2047));
        lat_a(5, 5'b11111, "full");
        @(posedge clk); #1;
        chk("full_idle_ready", 64'(rdy_a), 64'd1);
        chk("full_idle_busy", 64'(busy_a), 64'd0);

        // Send a sparse vector where only lanes 1 and 4 are valid.
        send_a(5'b10010, pack5(55, -5, 66, 77, 100), pack5(0, 0, 0, 0, 100));
        lat_a(2, 5'b10010, "sparse");
        @(posedge clk); #1;
        chk("sparse_idle_ready", 64'(rdy_a), 64'd1);

        // Apply backpressure in DONE.
        ro_a = 1'b0;
        send_a(5'b00111, pack5(1, -1, 300, 9, 9), pack5(1, 0, 300, 0, 0));
        lat_a(3, 5'b00111, "bp");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_vo", i), 64'(vo_a), 64'(5'b00111));
            chk($sformatf("bp_hold%0d_do", i), 64'(do_a_flat), 64'(pack5(1, 0, 300, 0, 0)));
            chk($sformatf("bp_hold%0d_rdy", i), 64'(rdy_a), 64'd0);
            chk($sformatf("bp_hold%0d_busy", i), 64'(busy_a), 64'd1);
        end
        ro_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_rdy", 64'(rdy_a), 64'd1);
        chk("bp_release_busy", 64'(busy_a), 64'd0);
        chk("bp_release_vo", 64'(vo_a), 64'd0);

        // Hold valid_in at zero, then send a single-lane vector.
        vi_a = '0;
        set_a(pack5(11, 12, 13, 14, 15));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("novalid%0d_busy", i), 64'(busy_a), 64'd0);
            chk($sformatf("novalid%0d_rdy", i), 64'(rdy_a), 64'd1);
        end
        send_a(5'b00001, pack5(9, 0, 0, 0, 0), pack5(9, 0, 0, 0, 0));
        lat_a(1, 5'b00001, "single");
        @(posedge clk); #1;

        // Reset partway through RUN, then send a fresh vector.
        send_a(5'b11111, pack5(10, 20, 30, 40, 50), pack5(10, 20, 30, 40, 50));
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_ready_in", 64'(rdy_a), 64'd1);
        chk("midrst_valid_out", 64'(vo_a), 64'd0);
        chk("midrst_data_out", 64'(do_a_flat), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        qa.delete();
        @(negedge clk); rst = 1'b1;
        send_a(5'b11111, pack5(-1, 5, -7, 8, 0), pack5(0, 5, 0, 8, 0));
        lat_a(5, 5'b11111, "postrst");
        @(posedge clk); #1;

        // Send two back-to-back passthrough vectors.
        send_b(pack5(-1, -2, 3, 4, -5), a1);
        send_b(pack5(100, -100, 2047, -2048, 0), a2);
        vi_b = '0;
        chk("pass_period", 64'(a2 - a1), 64'd7);

        // Drain both scoreboards.
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || busy_b) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        chk("b_final_ready", 64'(rdy_b), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
